// File: rtl/demux1xn_stream.sv
// 1-to-N stream demultiplexer: each input beat is steered by in_sel into a
// single registered slot per output channel; channels drain independently.
module demux1xn_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic                 sel_err,
    output logic [7:0]           err_cnt
);

    logic [N-1:0]                valid_q, valid_d;
    logic [N-1:0][WIDTH-1:0]     data_q, data_d;
    logic                        sel_err_q, sel_err_d;
    logic [7:0]                  err_cnt_q, err_cnt_d;
    logic                        in_ready_c;
    logic                        in_range;
    logic                        accept;

    // With a power-of-two channel count every select value names a channel.
    if ((1 << SELW) == N) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = (in_sel <= SELW'(N - 1));
    end

    // Out-of-range selects match no channel, so they are always accepted.
    always_comb begin
        in_ready_c = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SELW'(k)) begin
                in_ready_c = !valid_q[k] || out_ready[k];
            end
        end
    end

    assign accept = in_valid && in_ready_c;

    // Drain first, then a fill on the same channel overrides the drain.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        sel_err_d = 1'b0;
        err_cnt_d = err_cnt_q;
        for (int k = 0; k < N; k++) begin
            if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end
            if (accept && (in_sel == SELW'(k))) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end
        end
        if (accept && !in_range) begin
            sel_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
